// File: rtl/ysyx_22040729_decode_stage_if.sv
// Handshaked bus between IFU, the decode stage and EXU.
// The master side supplies instructions and sinks the decoded bundle; the slave side is the decode stage.
interface ysyx_22040729_decode_stage_if #(
  parameter int XLEN     = 64,
  parameter int PC_WIDTH = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [PC_WIDTH-1:0] in_pc;
  logic [31:0]         in_inst;

  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  logic [2:0]          out_funct3;
  logic                out_rf_we;
  logic [2:0]          out_rf_wdata_src;
  logic [1:0]          out_npc_src;
  logic [1:0]          out_alu_model;
  logic                out_alu_len_dw;
  logic                out_alu_src2_ri;
  logic                out_mem_ren;
  logic                out_mem_wen;
  logic                out_muldiv;
  logic                out_csr_en;
  logic                out_ecall;
  logic                out_mret;
  logic                out_illegal;
  logic [XLEN-1:0]     out_imm;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_rf_we, out_rf_wdata_src, out_npc_src, out_alu_model, out_alu_len_dw,
           out_alu_src2_ri, out_mem_ren, out_mem_wen, out_muldiv, out_csr_en,
           out_ecall, out_mret, out_illegal, out_imm
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_rf_we, out_rf_wdata_src, out_npc_src, out_alu_model, out_alu_len_dw,
           out_alu_src2_ri, out_mem_ren, out_mem_wen, out_muldiv, out_csr_en,
           out_ecall, out_mret, out_illegal, out_imm
  );
endinterface

// File: rtl/ysyx_22040729_decode_stage.sv
// Registered RV32/RV64 decode stage: decodes {pc, inst} into the EXU control bundle one cycle later.
// A one-entry skid register keeps in_ready purely registered (it never depends on out_ready).
module ysyx_22040729_decode_stage #(
  parameter int XLEN     = 64,
  parameter int ENABLE_M = 1,
  parameter int PC_WIDTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ysyx_22040729_decode_stage_if.slave bus
);

  typedef enum logic [4:0] {
    OPC_LOAD      = 5'b00000,
    OPC_MISC_MEM  = 5'b00011,
    OPC_OP_IMM    = 5'b00100,
    OPC_AUIPC     = 5'b00101,
    OPC_OP_IMM_32 = 5'b00110,
    OPC_STORE     = 5'b01000,
    OPC_OP        = 5'b01100,
    OPC_LUI       = 5'b01101,
    OPC_OP_32     = 5'b01110,
    OPC_BRANCH    = 5'b11000,
    OPC_JALR      = 5'b11001,
    OPC_JAL       = 5'b11011,
    OPC_SYSTEM    = 5'b11100
  } opcode_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic                rf_we;
    logic [2:0]          rf_wdata_src;
    logic [1:0]          npc_src;
    logic [1:0]          alu_model;
    logic                alu_len_dw;
    logic                alu_src2_ri;
    logic                mem_ren;
    logic                mem_wen;
    logic                muldiv;
    logic                csr_en;
    logic                ecall;
    logic                mret;
    logic                illegal;
    logic [XLEN-1:0]     imm;
  } bundle_t;

  logic [31:0]        inst;
  opcode_e            opcode;
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic               known, is_m, wide_bad, m_bad, sys_bad;
  bundle_t            dec;

  bundle_t out_q, skid_q;
  logic    out_valid_q, skid_valid_q;
  logic    accept;

  assign inst   = bus.in_inst;
  assign opcode = opcode_e'(inst[6:2]);

  // Immediates are formed at 32 bits then sign-extended to XLEN by the signed size cast.
  assign imm_i32 = {{20{inst[31]}}, inst[31:20]};
  assign imm_s32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u32 = {inst[31:12], 12'b0};
  assign imm_j32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i32);
  assign imm_s   = XLEN'(imm_s32);
  assign imm_b   = XLEN'(imm_b32);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_j   = XLEN'(imm_j32);

  assign is_m     = (inst[31:25] == 7'b0000001);
  assign wide_bad = (XLEN == 32) && (opcode == OPC_OP_IMM_32 || opcode == OPC_OP_32);
  assign m_bad    = (ENABLE_M == 0) && is_m && (opcode == OPC_OP || opcode == OPC_OP_32);
  assign sys_bad  = (opcode == OPC_SYSTEM) && (inst[14:12] == 3'd0) &&
                    (inst != 32'h0000_0073) && (inst != 32'h3020_0073);

  always_comb begin
    dec        = '0;
    known      = 1'b1;
    dec.pc     = bus.in_pc;
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.rd     = inst[11:7];
    dec.funct3 = inst[14:12];
    dec.ecall  = (inst == 32'h0000_0073);
    dec.mret   = (inst == 32'h3020_0073);
    case (opcode)
      OPC_LUI:    begin dec.rf_we = 1'b1; dec.rf_wdata_src = 3'd2; dec.imm = imm_u; end
      OPC_AUIPC:  begin dec.rf_we = 1'b1; dec.rf_wdata_src = 3'd3; dec.imm = imm_u; end
      OPC_JAL:    begin dec.rf_we = 1'b1; dec.npc_src = 2'd1; dec.imm = imm_j; end
      OPC_JALR: begin
        dec.rf_we = 1'b1; dec.npc_src = 2'd2; dec.alu_src2_ri = 1'b1; dec.imm = imm_i;
      end
      OPC_BRANCH: begin dec.npc_src = 2'd3; dec.alu_model = 2'd3; dec.imm = imm_b; end
      OPC_LOAD: begin
        dec.rf_we = 1'b1; dec.mem_ren = 1'b1; dec.rf_wdata_src = 3'd1;
        dec.alu_src2_ri = 1'b1; dec.imm = imm_i;
      end
      OPC_STORE:  begin dec.mem_wen = 1'b1; dec.alu_src2_ri = 1'b1; dec.imm = imm_s; end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        dec.rf_we = 1'b1; dec.alu_model = 2'd2; dec.alu_src2_ri = 1'b1; dec.imm = imm_i;
        dec.alu_len_dw = (opcode == OPC_OP_IMM_32);
      end
      OPC_OP, OPC_OP_32: begin
        dec.rf_we = 1'b1; dec.alu_model = 2'd1; dec.muldiv = is_m;
        dec.alu_len_dw = (opcode == OPC_OP_32);
      end
      OPC_SYSTEM: begin
        dec.rf_we = 1'b1; dec.alu_src2_ri = 1'b1; dec.rf_wdata_src = 3'd4; dec.imm = imm_i;
        dec.csr_en = (inst[14:12] != 3'd0);
      end
      OPC_MISC_MEM: dec.imm = imm_i;
      default:      known = 1'b0;
    endcase
    dec.illegal = (inst[1:0] != 2'b11) || !known || wide_bad || m_bad || sys_bad;
    if (XLEN == 32) dec.alu_len_dw = 1'b0;
    // An illegal bundle still flows to EXU for trapping, but must have no architectural side effects.
    if (dec.illegal) begin
      dec.rf_we   = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.muldiv  = 1'b0;
      dec.csr_en  = 1'b0;
    end
  end

  assign bus.in_ready = !skid_valid_q;
  assign accept       = bus.in_valid && !skid_valid_q;

  // Output slot frees when empty or draining; the skid entry always refills it before new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_pc           = out_q.pc;
  assign bus.out_rs1          = out_q.rs1;
  assign bus.out_rs2          = out_q.rs2;
  assign bus.out_rd           = out_q.rd;
  assign bus.out_funct3       = out_q.funct3;
  assign bus.out_rf_we        = out_q.rf_we;
  assign bus.out_rf_wdata_src = out_q.rf_wdata_src;
  assign bus.out_npc_src      = out_q.npc_src;
  assign bus.out_alu_model    = out_q.alu_model;
  assign bus.out_alu_len_dw   = out_q.alu_len_dw;
  assign bus.out_alu_src2_ri  = out_q.alu_src2_ri;
  assign bus.out_mem_ren      = out_q.mem_ren;
  assign bus.out_mem_wen      = out_q.mem_wen;
  assign bus.out_muldiv       = out_q.muldiv;
  assign bus.out_csr_en       = out_q.csr_en;
  assign bus.out_ecall        = out_q.ecall;
  assign bus.out_mret         = out_q.mret;
  assign bus.out_illegal      = out_q.illegal;
  assign bus.out_imm          = out_q.imm;

endmodule

// File: tb/tb_ysyx_22040729_decode_stage.sv
// Bench for the decode stage: three configurations (RV64+M, RV64 without M, RV32+M) share one stimulus
// stream; a scoreboard of model bundles is checked whenever the outputs transfer.
module tb_ysyx_22040729_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        rf_we;
    logic [2:0]  wsrc;
    logic [1:0]  npc;
    logic [1:0]  alum;
    logic        dw;
    logic        ri;
    logic        ren;
    logic        wen;
    logic        muldiv;
    logic        csr;
    logic        ecall;
    logic        mret;
    logic        illegal;
    logic [63:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  int          total = 0;
  int          bad = 0;
  exp_t [2:0]  sbq[$];

  always #5 clk = ~clk;

  ysyx_22040729_decode_stage_if #(.XLEN(64), .PC_WIDTH(64)) bus0 ();
  ysyx_22040729_decode_stage_if #(.XLEN(64), .PC_WIDTH(64)) bus1 ();
  ysyx_22040729_decode_stage_if #(.XLEN(32), .PC_WIDTH(64)) bus2 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
  assign bus0.in_pc = in_pc;        assign bus1.in_pc = in_pc;        assign bus2.in_pc = in_pc;
  assign bus0.in_inst = in_inst;    assign bus1.in_inst = in_inst;    assign bus2.in_inst = in_inst;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

  ysyx_22040729_decode_stage #(.XLEN(64), .ENABLE_M(1), .PC_WIDTH(64)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0));
  ysyx_22040729_decode_stage #(.XLEN(64), .ENABLE_M(0), .PC_WIDTH(64)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1));
  ysyx_22040729_decode_stage #(.XLEN(32), .ENABLE_M(1), .PC_WIDTH(64)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2));

  exp_t act0, act1, act2;
  exp_t [2:0] act_all;
  logic [2:0] out_fire;
  assign act0 = {bus0.out_pc, bus0.out_rs1, bus0.out_rs2, bus0.out_rd, bus0.out_funct3, bus0.out_rf_we,
                 bus0.out_rf_wdata_src, bus0.out_npc_src, bus0.out_alu_model, bus0.out_alu_len_dw,
                 bus0.out_alu_src2_ri, bus0.out_mem_ren, bus0.out_mem_wen, bus0.out_muldiv,
                 bus0.out_csr_en, bus0.out_ecall, bus0.out_mret, bus0.out_illegal, bus0.out_imm};
  assign act1 = {bus1.out_pc, bus1.out_rs1, bus1.out_rs2, bus1.out_rd, bus1.out_funct3, bus1.out_rf_we,
                 bus1.out_rf_wdata_src, bus1.out_npc_src, bus1.out_alu_model, bus1.out_alu_len_dw,
                 bus1.out_alu_src2_ri, bus1.out_mem_ren, bus1.out_mem_wen, bus1.out_muldiv,
                 bus1.out_csr_en, bus1.out_ecall, bus1.out_mret, bus1.out_illegal, bus1.out_imm};
  assign act2 = {bus2.out_pc, bus2.out_rs1, bus2.out_rs2, bus2.out_rd, bus2.out_funct3, bus2.out_rf_we,
                 bus2.out_rf_wdata_src, bus2.out_npc_src, bus2.out_alu_model, bus2.out_alu_len_dw,
                 bus2.out_alu_src2_ri, bus2.out_mem_ren, bus2.out_mem_wen, bus2.out_muldiv,
                 bus2.out_csr_en, bus2.out_ecall, bus2.out_mret, bus2.out_illegal, 64'(bus2.out_imm)};
  assign act_all  = {act2, act1, act0};
  assign out_fire = {bus2.out_valid && out_ready, bus1.out_valid && out_ready, bus0.out_valid && out_ready};

  // Reference decoder written from the ISA encoding tables; 32-bit results carry a zero upper imm half.
  function automatic exp_t model(input logic [63:0] pc, input logic [31:0] inst, input int xlen, input int em);
    exp_t e;
    logic [4:0] op;
    logic [63:0] ii, ss, bb, uu, jj;
    bit known, mul_enc;
    e = '0;
    e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7]; e.funct3 = inst[14:12];
    op = inst[6:2];
    ii = {{52{inst[31]}}, inst[31:20]};
    ss = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    bb = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    uu = {{32{inst[31]}}, inst[31:12], 12'h000};
    jj = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    mul_enc = (inst[31:25] == 7'b0000001) && (op == 5'b01100 || op == 5'b01110);
    known = 1;
    e.ecall = (inst == 32'h00000073);
    e.mret = (inst == 32'h30200073);
    case (op)
      5'b01101: begin e.rf_we = 1; e.wsrc = 2; e.imm = uu; end
      5'b00101: begin e.rf_we = 1; e.wsrc = 3; e.imm = uu; end
      5'b11011: begin e.rf_we = 1; e.npc = 1; e.imm = jj; end
      5'b11001: begin e.rf_we = 1; e.npc = 2; e.ri = 1; e.imm = ii; end
      5'b11000: begin e.npc = 3; e.alum = 3; e.imm = bb; end
      5'b00000: begin e.rf_we = 1; e.ren = 1; e.wsrc = 1; e.ri = 1; e.imm = ii; end
      5'b01000: begin e.wen = 1; e.ri = 1; e.imm = ss; end
      5'b00100: begin e.rf_we = 1; e.alum = 2; e.ri = 1; e.imm = ii; end
      5'b00110: begin e.rf_we = 1; e.alum = 2; e.ri = 1; e.imm = ii; e.dw = 1; end
      5'b01100: begin e.rf_we = 1; e.alum = 1; e.muldiv = mul_enc && em != 0; end
      5'b01110: begin e.rf_we = 1; e.alum = 1; e.dw = 1; e.muldiv = mul_enc && em != 0; end
      5'b11100: begin e.rf_we = 1; e.ri = 1; e.wsrc = 4; e.imm = ii; e.csr = (inst[14:12] != 0); end
      5'b00011: e.imm = ii;
      default:  known = 0;
    endcase
    e.illegal = !known || inst[1:0] != 2'b11 || (xlen == 32 && (op == 5'b00110 || op == 5'b01110)) ||
                (em == 0 && mul_enc) ||
                (op == 5'b11100 && inst[14:12] == 0 && !e.ecall && !e.mret);
    if (e.illegal) begin e.rf_we = 0; e.ren = 0; e.wen = 0; e.muldiv = 0; e.csr = 0; end
    if (xlen == 32) begin e.dw = 0; e.imm = {32'h0, e.imm[31:0]}; end
    return e;
  endfunction

  // Scoreboard: push on every accepted input, pop and compare on every output transfer.
  always @(negedge clk) begin
    exp_t [2:0] trio;
    if (rst || flush) sbq.delete();
    else begin
      if (out_fire != 3'b000) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL sb_unexpected_output got pc=%h want=no output", bus0.out_pc);
        end else begin
          trio = sbq.pop_front();
          for (int i = 0; i < 3; i++) begin
            total++;
            if (!out_fire[i] || act_all[i] !== trio[i]) begin
              bad++;
              $display("[TB] FAIL sb_dut%0d got=%h want=%h", i, act_all[i], trio[i]);
            end
          end
        end
      end
      if (in_valid && bus0.in_ready) begin
        trio = {model(in_pc, in_inst, 32, 1), model(in_pc, in_inst, 64, 0), model(in_pc, in_inst, 64, 1)};
        sbq.push_back(trio);
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1; flush = 0;
    repeat (2) cycle();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", bus0.out_valid); end
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", bus0.in_ready); end
    total++; if (bus0.out_pc !== 64'h0 || bus0.out_imm !== 64'h0) begin bad++; $display("[TB] FAIL rst_data got pc=%h imm=%h want=0", bus0.out_pc, bus0.out_imm); end
    total++; if (bus2.out_valid !== 1'b0 || bus2.out_rf_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_dut2 got v=%b we=%b want=0", bus2.out_valid, bus2.out_rf_we); end
    rst = 0;
    cycle();
  endtask

  task automatic test_addi();
    in_pc = 64'h8000_0000; in_inst = 32'h0050_0093; in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid got=%b want=1", bus0.out_valid); end
    total++; if (bus0.out_rd !== 5'd1 || bus0.out_rs1 !== 5'd0) begin bad++; $display("[TB] FAIL addi_regs got rd=%0d rs1=%0d want 1,0", bus0.out_rd, bus0.out_rs1); end
    total++; if (bus0.out_imm !== 64'd5) begin bad++; $display("[TB] FAIL addi_imm got=%h want=5", bus0.out_imm); end
    total++; if (bus0.out_rf_we !== 1'b1 || bus0.out_alu_model !== 2'd2 || bus0.out_alu_src2_ri !== 1'b1 || bus0.out_illegal !== 1'b0)
      begin bad++; $display("[TB] FAIL addi_ctrl got we=%b am=%0d ri=%b ill=%b want 1,2,1,0", bus0.out_rf_we, bus0.out_alu_model, bus0.out_alu_src2_ri, bus0.out_illegal); end
    cycle();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_drained got=%b want=0", bus0.out_valid); end
  endtask

  task automatic test_lui_beq();
    in_pc = 64'h100; in_inst = 32'h8000_0137; in_valid = 1; out_ready = 1;
    cycle();
    total++; if (bus0.out_imm !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("[TB] FAIL lui_imm got=%h want=ffffffff80000000", bus0.out_imm); end
    total++; if (bus0.out_rf_wdata_src !== 3'd2 || bus0.out_rd !== 5'd2) begin bad++; $display("[TB] FAIL lui_ctrl got src=%0d rd=%0d want 2,2", bus0.out_rf_wdata_src, bus0.out_rd); end
    total++; if (bus2.out_imm !== 32'h8000_0000) begin bad++; $display("[TB] FAIL lui32_imm got=%h want=80000000", bus2.out_imm); end
    in_pc = 64'h104; in_inst = 32'hFE00_0EE3;
    cycle();
    in_valid = 0;
    total++; if (bus0.out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("[TB] FAIL beq_imm got=%h want=fffffffffffffffc", bus0.out_imm); end
    total++; if (bus0.out_npc_src !== 2'd3 || bus0.out_rf_we !== 1'b0) begin bad++; $display("[TB] FAIL beq_ctrl got npc=%0d we=%b want 3,0", bus0.out_npc_src, bus0.out_rf_we); end
    cycle();
  endtask

  task automatic test_mul_illegal();
    in_pc = 64'h200; in_inst = 32'h0231_00B3; in_valid = 1; out_ready = 1;
    cycle();
    total++; if (bus0.out_muldiv !== 1'b1 || bus0.out_rf_we !== 1'b1 || bus0.out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL mul_m1 got md=%b we=%b ill=%b want 1,1,0", bus0.out_muldiv, bus0.out_rf_we, bus0.out_illegal); end
    total++; if (bus1.out_illegal !== 1'b1 || bus1.out_rf_we !== 1'b0 || bus1.out_muldiv !== 1'b0) begin bad++; $display("[TB] FAIL mul_m0 got ill=%b we=%b md=%b want 1,0,0", bus1.out_illegal, bus1.out_rf_we, bus1.out_muldiv); end
    in_pc = 64'h204; in_inst = 32'hFFFF_FFFF;
    cycle();
    in_valid = 0;
    total++; if (bus0.out_illegal !== 1'b1 || bus2.out_illegal !== 1'b1 || bus0.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ones_illegal got ill=%b/%b v=%b want 1,1,1", bus0.out_illegal, bus2.out_illegal, bus0.out_valid); end
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1;
    in_pc = 64'h300; in_inst = 32'h0050_0093;
    cycle();
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready1 got=%b want=1", bus0.in_ready); end
    in_pc = 64'h304; in_inst = 32'h8000_0137;
    cycle();
    total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ready2 got=%b want=0", bus0.in_ready); end
    in_pc = 64'h308; in_inst = 32'h0231_00B3;
    cycle();
    total++; if (bus0.in_ready !== 1'b0 || bus0.out_pc !== 64'h300 || bus0.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stall got rdy=%b pc=%h v=%b want 0,300,1", bus0.in_ready, bus0.out_pc, bus0.out_valid); end
    out_ready = 1;
    cycle();
    total++; if (bus0.out_pc !== 64'h304 || bus0.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second got pc=%h v=%b want 304,1", bus0.out_pc, bus0.out_valid); end
    cycle();
    in_valid = 0;
    total++; if (bus0.out_pc !== 64'h308 || bus0.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_third got pc=%h v=%b want 308,1", bus0.out_pc, bus0.out_valid); end
    cycle();
    total++; if (bus0.out_valid !== 1'b0 || sbq.size() != 0) begin bad++; $display("[TB] FAIL b2b_end got v=%b pending=%0d want 0,0", bus0.out_valid, sbq.size()); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    in_pc = 64'h400; in_inst = 32'h0050_0093;
    cycle();
    in_pc = 64'h404; in_inst = 32'h0000_B103;
    cycle();
    total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_full got rdy=%b want=0", bus0.in_ready); end
    flush = 1; in_pc = 64'h408; in_inst = 32'h0010_0093;
    cycle();
    flush = 0; in_valid = 0;
    total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_state got v=%b rdy=%b want 0,1", bus0.out_valid, bus0.in_ready); end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_leak got v=%b pc=%h want v=0", bus0.out_valid, bus0.out_pc); end
    end
  endtask

  task automatic test_addiw_rst_stall();
    in_pc = 64'h500; in_inst = 32'h0010_009B; in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    total++; if (bus2.out_illegal !== 1'b1 || bus2.out_alu_len_dw !== 1'b0 || bus2.out_rf_we !== 1'b0) begin bad++; $display("[TB] FAIL addiw32 got ill=%b dw=%b we=%b want 1,0,0", bus2.out_illegal, bus2.out_alu_len_dw, bus2.out_rf_we); end
    total++; if (bus0.out_illegal !== 1'b0 || bus0.out_alu_len_dw !== 1'b1) begin bad++; $display("[TB] FAIL addiw64 got ill=%b dw=%b want 0,1", bus0.out_illegal, bus0.out_alu_len_dw); end
    cycle();
    out_ready = 0; in_valid = 1;
    in_pc = 64'h600; in_inst = 32'h0050_0093;
    cycle();
    in_pc = 64'h604;
    cycle();
    rst = 1; in_valid = 0;
    cycle();
    rst = 0;
    total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.out_pc !== 64'h0) begin bad++; $display("[TB] FAIL rst_stall got v=%b rdy=%b pc=%h want 0,1,0", bus0.out_valid, bus0.in_ready, bus0.out_pc); end
    out_ready = 1;
    cycle();
  endtask

  task automatic test_random_stream();
    logic [31:0] pool [16];
    pool = '{32'h0050_0093, 32'h8000_0137, 32'hFE00_0EE3, 32'h0231_00B3, 32'hFFFF_FFFF, 32'h0000_B103,
             32'h0020_B423, 32'h0080_00EF, 32'h0000_80E7, 32'h0000_1097, 32'h0000_0073, 32'h3020_0073,
             32'h3052_9073, 32'h0010_0073, 32'h0FF0_000F, 32'h0000_4501};
    for (int i = 0; i < 200; i++) begin
      in_pc = 64'h1000 + 64'(i) * 4;
      in_inst = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 15)];
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) cycle();
    total++; if (sbq.size() != 0) begin bad++; $display("[TB] FAIL random_drain got pending=%0d want=0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_beq();
    test_mul_illegal();
    test_back_to_back();
    test_flush();
    test_addiw_rst_stall();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ysyx_22040729_decode_stage.md
Name: ysyx_22040729_decode_stage

Overview:
Registered, handshaked RV32/RV64 decode stage sitting between IFU and EXU. It is the pipelined successor of the combinational decoder.
- Accepts {pc, inst} on a valid/ready interface and emits the fully decoded control bundle one cycle later.
- Contains a 1-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Adds over the prior decoder: XLEN generalisation, optional M extension, load/funct3 passthrough, register indices, illegal-instruction detection, and flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64
ENABLE_M, 1, 1 = decode MUL/DIV (funct7 = 0000001 on OP / OP-32); 0 = treat them as illegal
PC_WIDTH, 64, program-counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  discard all held/accepted instructions (redirect)
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_pc  in  PC_WIDTH  instruction PC
in_inst  in  32  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  PC_WIDTH  PC of the decoded instruction
out_rs1, out_rs2, out_rd  out  5 each  register indices (inst[19:15], [24:20], [11:7])
out_funct3  out  3  inst[14:12]
out_rf_we  out  1  register-file write
out_rf_wdata_src  out  3  0 alu, 1 mem, 2 imm, 3 pc+imm, 4 csr
out_npc_src  out  2  0 seq, 1 jal, 2 jalr, 3 branch
out_alu_model  out  2  0 add, 1 R-funct, 2 I-funct, 3 compare
out_alu_len_dw  out  1  32-bit word op (OP-32 / OP-IMM-32)
out_alu_src2_ri  out  1  1 = immediate operand
out_mem_ren, out_mem_wen  out  1 each  load / store
out_muldiv  out  1  M-extension op
out_csr_en, out_ecall, out_mret  out  1 each  system decode
out_illegal  out  1  unsupported encoding
out_imm  out  XLEN  sign-extended I/S/B/U/J immediate

Behaviour:
- Reset (synchronous, active-high) and handshake:
  - rst: out_valid=0, skid empty, in_ready=1 in the following cycle; all out_* data registers = 0.
  - Latency: 1 cycle. A transfer on cycle N (in_valid & in_ready) gives out_valid=1 from N+1.
  - Transfer occurs when valid & ready on either side. out_* hold stable while out_valid & !out_ready.
  - in_ready = !skid_valid (registered).
  - If the output register is full and stalled when an input is accepted, the decoded bundle goes to the skid register. When the output drains, the skid moves to the output the next cycle. Order is preserved, with no loss and no duplication.
  - Simultaneous output drain plus input accept with skid empty: the new bundle loads directly into the output register and out_valid stays 1.
- Flush:
  - Same-cycle priority over everything.
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input presented during the flush cycle is dropped.
- Decode (on opcode[6:2]): LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, SYSTEM, MISC-MEM (FENCE decodes as a NOP: rf_we=0).
- Control encoding:
  - rf_we: 1 for R/I/U/J/SYSTEM; 0 for S/B/FENCE.
  - alu_src2_ri: 1 for I/S/SYSTEM.
  - mem_ren: 1 only for LOAD, and LOAD sets rf_wdata_src=1.
- Immediate: per RISC-V formats, sign-extended from inst[31] to XLEN.
  - U type: imm = {inst[31:12], 12'b0} sign-extended.
  - R type: imm = 0.
- System decode:
  - ecall iff inst == 0x00000073.
  - mret iff inst == 0x30200073.
  - csr_en iff SYSTEM with funct3 != 0.
- illegal=1 for any of:
  - inst[1:0] != 2'b11
  - undefined opcode
  - OP-32 / OP-IMM-32 when XLEN=32
  - funct7=0000001 with ENABLE_M=0
  - SYSTEM funct3=0 other than ecall/mret
- When illegal=1, rf_we, mem_ren, mem_wen, muldiv and csr_en are forced to 0. The bundle still flows with out_valid=1.
- When XLEN=32, alu_len_dw is constant 0.

Test Plan:
- Reset, then in_valid with inst 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, rd=1, rs1=0, imm=5, rf_we=1, alu_model=2, alu_src2_ri=1, illegal=0.
- XLEN=64, inst 0x80000137 (lui x2,0x80000) -> imm=0xFFFFFFFF80000000, rf_wdata_src=2, rd=2; inst 0xFE000EE3 (beq x0,x0,-4) -> imm=-4, npc_src=3, rf_we=0.
- out_ready held 0 while 3 back-to-back valid instructions are offered -> first two accepted, in_ready=0 on the third. After out_ready=1, all three emerge in order with no gaps or duplicates.
- inst 0x023100B3 (mul x1,x2,x3): ENABLE_M=1 -> muldiv=1, rf_we=1; ENABLE_M=0 -> illegal=1, rf_we=0. inst 0xFFFFFFFF -> illegal=1.
- Output and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle input never appears.
- XLEN=32, inst 0x0010009B (addiw) -> illegal=1, alu_len_dw=0; rst asserted mid-stall -> out_valid=0 the next cycle.
